dragon_body_controller: RTL and testbench
=========================================

Name: dragon_body_controller

Overview:
- Produces the dragon's segment position bus and active-segment mask that the collision checker consumes each frame.
- Moves the head one grid cell toward a chase target on divided frame ticks and shifts the body along behind it.
- Grows the body when a sheep is eaten and shrinks it on a sword hit.
- Signals defeat when the last segment is destroyed.

Parameters:
- GRID_W, 16: grid columns; x range 0..GRID_W-1.
- GRID_H, 12: grid rows; y range 0..GRID_H-1.
- MOVE_DIV, 4: number of move_tick pulses per dragon step (1..15).
- START_POS, 8'h55: reset position of every segment, encoded {y[3:0], x[3:0]}.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- move_tick  in  1  one-cycle pulse per video frame.
- targetPos  in  8  chase target {y, x}, normally the player position.
- grow  in  1  one-cycle pulse: sheep eaten.
- hit  in  1  one-cycle pulse: sword struck the dragon.
- dragonSegmentPositions  out  56  7 x 8-bit positions; [7:0] = head (seg0), [55:48] = seg6.
- activeDragonSegments  out  7  bit i set means seg i is active.
- dragonDirection  out  2  last move direction: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1).
- dragonLength  out  3  active segment count, 1..7.
- dragonDefeated  out  1  high while in DEFEATED state.

Behaviour:
- Reset (reset==0 at posedge), all registered:
  - All seven segments = START_POS.
  - dragonLength = 1; activeDragonSegments = 7'b0000001.
  - dragonDirection = 00; dragonDefeated = 0.
  - Divider count = 0; grow_pending = 0; state = ACTIVE.
- Reset mid-operation discards any pending grow and the divider count.
- Active mask is always (1 << dragonLength) - 1, registered and updated in the same edge as dragonLength.
- States:
  - ACTIVE: normal operation.
  - DEFEATED: all outputs frozen, all inputs ignored; exit only via reset.
- Divider:
  - On move_tick in ACTIVE: if count == MOVE_DIV-1, a step occurs and count returns to 0; otherwise count increments.
  - With no move_tick, count holds.
- Target clamp:
  - tx = min(targetPos[3:0], GRID_W-1).
  - ty = min(targetPos[7:4], GRID_H-1).
- Step direction, head (hx, hy):
  - dx = |tx-hx|, dy = |ty-hy|, computed in 5-bit unsigned.
  - If dx==0 and dy==0: no move. Positions and direction hold; the step still consumes grow_pending.
  - Else if dx >= dy: move in x (x ties go to x), right if tx>hx, else left.
  - Else: move in y, down if ty>hy, else up.
  - The head never leaves the grid because the target is clamped.
- Step update, one edge after the step-qualifying cycle:
  - seg[i] <= seg[i-1] for i = 6..1; seg0 <= new head; dragonDirection <= move direction.
  - Inactive segments shift too, so a newly grown segment takes the previous tail's trailing position.
- Grow:
  - A grow pulse sets grow_pending.
  - On the next step with grow_pending: dragonLength += 1 (saturates at 7) and grow_pending clears.
  - A grow at length 7 is consumed with no change.
  - Grow in the same cycle as a step: applies on that step.
- Hit (immediate, not step-gated):
  - If length > 1: dragonLength -= 1 on the next edge; the mask drops the tail bit.
  - If length == 1: next edge enters DEFEATED with dragonDefeated = 1.
- Simultaneous grow and hit in the same cycle:
  - The hit applies and the grow pulse is discarded.
  - An existing grow_pending is kept.
- Hit and step in the same cycle: both apply on the same edge (shift plus length decrement).
- Latency: all outputs registered; one cycle from the qualifying input to the output change.

Test Plan:
- Reset check: assert reset=0 for 2 cycles -> bus = 56'h55555555555555, mask 7'b0000001, length 1, direction 00, defeated 0.
- Chase in x: MOVE_DIV=1, targetPos=8'h58, 3 move_ticks -> seg0 steps 0x56, 0x57, 0x58 with direction 01; a 4th tick gives no move and seg0 stays 0x58.
- Tie and axis priority: head 0x55, target 0x33 -> first step goes left to 0x54, second goes up to 0x44.
- Divider: MOVE_DIV=4, 3 move_ticks -> no change; 4th tick -> head moves one cell on the following edge.
- Growth to saturation:
  - Pulse grow, then step -> length 2, mask 7'b0000011, seg1 = previous head.
  - Repeat 6 times -> length stays 7, mask 7'h7F.
- Hit, defeat and priority:
  - At length 2, hit -> length 1, mask 7'b0000001.
  - Hit again -> dragonDefeated=1; subsequent ticks, grow and hit cause no output change until reset.
  - Simultaneous grow+hit at length 3 -> length 2 and grow_pending stays 0.

Source files
------------

// File: rtl/dragon_body_controller.sv
// Dragon body controller: chases a clamped target one grid cell per divided
//   frame tick, shifts the body behind the head, grows on sheep, shrinks on hits.
// Latency: all outputs registered, one clock from qualifying input to output change.
// Backpressure: none; single-cycle pulse inputs are consumed on the edge they are seen.
// Ports:
//   clk, reset (sync, active-low)                       - clock / reset
//   move_tick, targetPos, grow, hit                     - frame tick, chase target, events
//   dragonSegmentPositions, activeDragonSegments        - 7 x {y,x} bus (seg0 = [7:0]), mask
//   dragonDirection, dragonLength, dragonDefeated       - last move dir, segment count, defeat flag
module dragon_body_controller #(
  parameter int          GRID_W    = 16,
  parameter int          GRID_H    = 12,
  parameter int          MOVE_DIV  = 4,
  parameter logic [7:0]  START_POS = 8'h55
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        move_tick,
  input  logic [7:0]  targetPos,
  input  logic        grow,
  input  logic        hit,
  output logic [55:0] dragonSegmentPositions,
  output logic [6:0]  activeDragonSegments,
  output logic [1:0]  dragonDirection,
  output logic [2:0]  dragonLength,
  output logic        dragonDefeated
);

  localparam logic [3:0] X_MAX    = 4'(GRID_W - 1);
  localparam logic [3:0] Y_MAX    = 4'(GRID_H - 1);
  localparam logic [3:0] DIV_LAST = 4'(MOVE_DIV - 1);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic {ST_ACTIVE, ST_DEFEATED} state_t;

  state_t      r_state, w_state_nxt;
  logic [55:0] r_segs, w_segs_nxt;
  logic [6:0]  r_mask, w_mask_nxt;
  logic [2:0]  r_len, w_len_nxt;
  logic [1:0]  r_dir, w_dir_nxt;
  logic [3:0]  r_div, w_div_nxt;
  logic        r_grow_pend, w_grow_pend_nxt;

  logic        w_step, w_move, w_grow_now, w_grow_apply;
  logic [3:0]  w_tx, w_ty, w_hx, w_hy;
  logic [4:0]  w_dx, w_dy;
  logic [1:0]  w_move_dir;
  logic [7:0]  w_head_nxt;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_ACTIVE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_ACTIVE && hit && r_len == 3'd1)
      w_state_nxt = ST_DEFEATED;
  end

  // ------------------------------------------------------- step steering
  always_comb begin
    w_tx = (targetPos[3:0] > X_MAX) ? X_MAX : targetPos[3:0];
    w_ty = (targetPos[7:4] > Y_MAX) ? Y_MAX : targetPos[7:4];
    w_hx = r_segs[3:0];
    w_hy = r_segs[7:4];
    w_dx = (w_tx >= w_hx) ? {1'b0, w_tx - w_hx} : {1'b0, w_hx - w_tx};
    w_dy = (w_ty >= w_hy) ? {1'b0, w_ty - w_hy} : {1'b0, w_hy - w_ty};
    w_move = (w_dx != 5'd0) || (w_dy != 5'd0);

    w_move_dir = r_dir;
    w_head_nxt = r_segs[7:0];
    // Equal distances resolve toward the x axis.
    if (w_dx >= w_dy) begin
      if (w_tx > w_hx) begin
        w_move_dir = DIR_RIGHT;
        w_head_nxt = {w_hy, w_hx + 4'd1};
      end else begin
        w_move_dir = DIR_LEFT;
        w_head_nxt = {w_hy, w_hx - 4'd1};
      end
    end else begin
      if (w_ty > w_hy) begin
        w_move_dir = DIR_DOWN;
        w_head_nxt = {w_hy + 4'd1, w_hx};
      end else begin
        w_move_dir = DIR_UP;
        w_head_nxt = {w_hy - 4'd1, w_hx};
      end
    end
  end

  // ---------------------------------------------------- next-state datapath
  always_comb begin
    w_step     = move_tick && (r_div == DIV_LAST);
    w_div_nxt  = r_div;
    if (move_tick)
      w_div_nxt = (r_div == DIV_LAST) ? 4'd0 : r_div + 4'd1;

    // A hit in the same cycle swallows a fresh grow pulse; an older pending grow survives.
    w_grow_now      = r_grow_pend | (grow & ~hit);
    w_grow_apply    = w_step & w_grow_now & (r_len != 3'd7);
    w_grow_pend_nxt = w_step ? 1'b0 : w_grow_now;

    w_len_nxt = r_len;
    if (hit) begin
      // Last-segment hit defeats the dragon; length stays at 1.
      if (r_len != 3'd1 && !w_grow_apply)
        w_len_nxt = r_len - 3'd1;
    end else if (w_grow_apply) begin
      w_len_nxt = r_len + 3'd1;
    end
    w_mask_nxt = 7'((8'd1 << w_len_nxt) - 8'd1);

    w_segs_nxt = r_segs;
    w_dir_nxt  = r_dir;
    // Inactive segments shift as well so a grown tail lands on the old tail's trail.
    if (w_step && w_move) begin
      w_segs_nxt = {r_segs[47:0], w_head_nxt};
      w_dir_nxt  = w_move_dir;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_segs      <= {7{START_POS}};
      r_len       <= 3'd1;
      r_mask      <= 7'b0000001;
      r_dir       <= DIR_UP;
      r_div       <= 4'd0;
      r_grow_pend <= 1'b0;
    end else if (r_state == ST_ACTIVE) begin
      r_segs      <= w_segs_nxt;
      r_len       <= w_len_nxt;
      r_mask      <= w_mask_nxt;
      r_dir       <= w_dir_nxt;
      r_div       <= w_div_nxt;
      r_grow_pend <= w_grow_pend_nxt;
    end
  end

  assign dragonSegmentPositions = r_segs;
  assign activeDragonSegments   = r_mask;
  assign dragonDirection        = r_dir;
  assign dragonLength           = r_len;
  assign dragonDefeated         = (r_state == ST_DEFEATED);

endmodule

// File: tb/tb_dragon_body_controller.sv
module tb_dragon_body_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        move_tick = 1'b0;
  logic [7:0]  targetPos = 8'h00;
  logic        grow = 1'b0;
  logic        hit = 1'b0;

  logic [55:0] d1_pos, d4_pos;
  logic [6:0]  d1_mask, d4_mask;
  logic [1:0]  d1_dir, d4_dir;
  logic [2:0]  d1_len, d4_len;
  logic        d1_def, d4_def;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [55:0] segs;
    logic [2:0]  len;
    logic [1:0]  dir;
    logic [3:0]  div;
    logic        gp;
    logic        def;
  } model_t;

  model_t m1, m4;
  model_t q1[$];
  model_t q4[$];

  always #5 clk = ~clk;

  dragon_body_controller #(.MOVE_DIV(1)) u_d1 (
    .clk(clk), .reset(reset), .move_tick(move_tick), .targetPos(targetPos),
    .grow(grow), .hit(hit),
    .dragonSegmentPositions(d1_pos), .activeDragonSegments(d1_mask),
    .dragonDirection(d1_dir), .dragonLength(d1_len), .dragonDefeated(d1_def)
  );

  dragon_body_controller #(.MOVE_DIV(4)) u_d4 (
    .clk(clk), .reset(reset), .move_tick(move_tick), .targetPos(targetPos),
    .grow(grow), .hit(hit),
    .dragonSegmentPositions(d4_pos), .activeDragonSegments(d4_mask),
    .dragonDirection(d4_dir), .dragonLength(d4_len), .dragonDefeated(d4_def)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Behavioural reference for one clock edge.
  function automatic model_t mstep(input model_t m, input int div, input logic rs,
                                   input logic mt, input logic [7:0] tp,
                                   input logic g, input logic h);
    model_t n;
    int tx, ty, hx, hy, ddx, ddy;
    bit step, gnow;
    if (!rs) begin
      n.segs = {7{8'h55}};
      n.len = 3'd1; n.dir = 2'd0; n.div = 4'd0; n.gp = 1'b0; n.def = 1'b0;
      return n;
    end
    if (m.def) return m;
    n = m;
    step = mt && (int'(m.div) == div - 1);
    if (mt) n.div = step ? 4'd0 : m.div + 4'd1;
    tx = int'(tp[3:0]); if (tx > 15) tx = 15;
    ty = int'(tp[7:4]); if (ty > 11) ty = 11;
    hx = int'(m.segs[3:0]);
    hy = int'(m.segs[7:4]);
    ddx = tx - hx;
    ddy = ty - hy;
    gnow = m.gp || (g && !h);
    if (step) begin
      if (ddx != 0 || ddy != 0) begin
        if (iabs(ddx) >= iabs(ddy)) begin
          if (ddx > 0) begin hx++; n.dir = 2'd1; end
          else         begin hx--; n.dir = 2'd3; end
        end else begin
          if (ddy > 0) begin hy++; n.dir = 2'd2; end
          else         begin hy--; n.dir = 2'd0; end
        end
        n.segs = {m.segs[47:0], 4'(hy), 4'(hx)};
      end
      if (gnow && m.len < 3'd7) n.len = m.len + 3'd1;
      n.gp = 1'b0;
    end else begin
      n.gp = gnow;
    end
    if (h) begin
      if (m.len == 3'd1) begin n.def = 1'b1; n.len = m.len; end
      else n.len = n.len - 3'd1;
    end
    return n;
  endfunction

  // Drive one cycle of inputs, predict both instances, then score the DUT outputs.
  task automatic cyc(input logic rs, input logic mt, input logic [7:0] tp,
                     input logic g, input logic h);
    model_t e;
    logic [7:0] msk;
    @(negedge clk);
    reset = rs; move_tick = mt; targetPos = tp; grow = g; hit = h;
    m1 = mstep(m1, 1, rs, mt, tp, g, h); q1.push_back(m1);
    m4 = mstep(m4, 4, rs, mt, tp, g, h); q4.push_back(m4);
    @(posedge clk);
    #1;
    e = q1.pop_front();
    msk = (8'd1 << e.len) - 8'd1;
    check("d1.pos", 64'(d1_pos), 64'(e.segs));
    check("d1.len", 64'(d1_len), 64'(e.len));
    check("d1.mask", 64'(d1_mask), 64'(msk[6:0]));
    check("d1.dir", 64'(d1_dir), 64'(e.dir));
    check("d1.def", 64'(d1_def), 64'(e.def));
    e = q4.pop_front();
    msk = (8'd1 << e.len) - 8'd1;
    check("d4.pos", 64'(d4_pos), 64'(e.segs));
    check("d4.len", 64'(d4_len), 64'(e.len));
    check("d4.mask", 64'(d4_mask), 64'(msk[6:0]));
    check("d4.dir", 64'(d4_dir), 64'(e.dir));
    check("d4.def", 64'(d4_def), 64'(e.def));
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    do_reset();
    check("rst.pos", 64'(d1_pos), 64'h0055555555555555);
    check("rst.mask", 64'(d1_mask), 64'h01);
    check("rst.len", 64'(d1_len), 64'd1);
    check("rst.dir", 64'(d1_dir), 64'd0);
    check("rst.def", 64'(d1_def), 64'd0);

    // Chase in x
    cyc(1'b1, 1'b1, 8'h58, 1'b0, 1'b0);
    check("chase1", 64'(d1_pos[7:0]), 64'h56);
    cyc(1'b1, 1'b1, 8'h58, 1'b0, 1'b0);
    check("chase2", 64'(d1_pos[7:0]), 64'h57);
    cyc(1'b1, 1'b1, 8'h58, 1'b0, 1'b0);
    check("chase3", 64'(d1_pos[7:0]), 64'h58);
    check("chase.dir", 64'(d1_dir), 64'd1);
    cyc(1'b1, 1'b1, 8'h58, 1'b0, 1'b0);
    check("chase.hold", 64'(d1_pos[7:0]), 64'h58);

    // Tie resolves to x, then y wins
    do_reset();
    cyc(1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
    check("tie.left", 64'(d1_pos[7:0]), 64'h54);
    check("tie.dir", 64'(d1_dir), 64'd3);
    cyc(1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
    check("tie.up", 64'(d1_pos[7:0]), 64'h44);
    check("tie.updir", 64'(d1_dir), 64'd0);

    // Divider, including reset discarding a partial count
    do_reset();
    cyc(1'b1, 1'b1, 8'h58, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h58, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'h58, 1'b0, 1'b0);
    check("div.wait", 64'(d4_pos[7:0]), 64'h55);
    cyc(1'b1, 1'b1, 8'h58, 1'b0, 1'b0);
    check("div.step", 64'(d4_pos[7:0]), 64'h56);

    // Clamp: out-of-range target y=15 clamps to 11 (down)
    do_reset();
    cyc(1'b1, 1'b1, 8'hF5, 1'b0, 1'b0);
    check("clamp.down", 64'(d1_pos[7:0]), 64'h65);

    // Growth to saturation
    do_reset();
    cyc(1'b1, 1'b0, 8'h5F, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'h5F, 1'b0, 1'b0);
    check("grow.len", 64'(d1_len), 64'd2);
    check("grow.mask", 64'(d1_mask), 64'h03);
    check("grow.seg1", 64'(d1_pos[15:8]), 64'h55);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 8'h5F, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 8'h5F, 1'b0, 1'b0);
    end
    check("grow.sat", 64'(d1_len), 64'd7);
    check("grow.satmask", 64'(d1_mask), 64'h7F);

    // Hit, defeat and freeze
    do_reset();
    cyc(1'b1, 1'b0, 8'h5F, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'h5F, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h5F, 1'b0, 1'b1);
    check("hit.len", 64'(d1_len), 64'd1);
    check("hit.mask", 64'(d1_mask), 64'h01);
    cyc(1'b1, 1'b0, 8'h5F, 1'b0, 1'b1);
    check("defeat", 64'(d1_def), 64'd1);
    cyc(1'b1, 1'b1, 8'h5F, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h5F, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'h5F, 1'b0, 1'b1);
    check("frozen.pos", 64'(d1_pos), 64'h0055555555555556);
    check("frozen.len", 64'(d1_len), 64'd1);
    check("frozen.def", 64'(d1_def), 64'd1);

    // Simultaneous grow and hit
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 8'h5F, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 8'h5F, 1'b0, 1'b0);
    end
    check("gh.len3", 64'(d1_len), 64'd3);
    cyc(1'b1, 1'b0, 8'h5F, 1'b1, 1'b1);
    check("gh.len2", 64'(d1_len), 64'd2);
    cyc(1'b1, 1'b1, 8'h5F, 1'b0, 1'b0);
    check("gh.nopend", 64'(d1_len), 64'd2);
    check("gh.head", 64'(d1_pos[7:0]), 64'h58);

    // Randomised traffic against the reference
    do_reset();
    for (int i = 0; i < 150; i++) begin
      cyc(($urandom_range(0, 40) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
